div_config_ctrl: RTL and testbench

Configuration sequencer that sits directly upstream of the frequency divider and drives its DIN_n, CONFIG_DIV and ENABLE inputs. It accepts divisor change requests over a valid/ready handshake and range-checks them. It then performs the safe update sequence on the divider: stop, quiet, load, settle, restart. The divider's output is therefore never reconfigured while it is running.

---
 rtl/div_config_ctrl.sv | 174 +++++++++++++++++
 tb/tb_div_config_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_config_ctrl.sv
// div_config_ctrl: safe reconfiguration sequencer for the frequency divider.
// Stops the divider, loads a range-checked divisor, settles, then restarts.
module div_config_ctrl #(
    parameter int unsigned QUIET_CYCLES = 2,
    parameter logic [31:0] MIN_DIV      = 32'd1,
    parameter logic [31:0] MAX_DIV      = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    input  logic [31:0] REQ_DIV,
    output logic        REQ_READY,
    input  logic        RUN_REQ,
    input  logic        ERR_CLR,
    output logic [31:0] DIN_n,
    output logic        CONFIG_DIV,
    output logic        ENABLE,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STOP,
        S_LOAD,
        S_SETTLE
    } state_t;

    localparam logic [7:0] QLOAD = 8'(QUIET_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] din_q, din_d;
    logic        err_q, err_d;

    logic        ready;
    logic        accept;
    logic        above_min;
    logic        below_max;
    logic        req_legal;

    // Lower bound: bounds of 0 or 1 reduce to the nonzero test below.
    generate
        if (MIN_DIV <= 32'd1) begin : g_min_trivial
            assign above_min = 1'b1;
        end else begin : g_min
            assign above_min = (REQ_DIV >= MIN_DIV);
        end
    endgenerate

    // Upper bound: a full-range maximum accepts everything.
    generate
        if (MAX_DIV == 32'hFFFF_FFFF) begin : g_max_trivial
            assign below_max = 1'b1;
        end else begin : g_max
            assign below_max = (REQ_DIV <= MAX_DIV);
        end
    endgenerate

    // Divisor 0 would stall the divider, so it is never legal.
    assign req_legal = (REQ_DIV != 32'd0) && above_min && below_max;

    // Requests are only taken while the divider is not being reconfigured.
    assign ready  = (state_q == S_IDLE) || (state_q == S_RUN);
    assign accept = REQ_VALID && ready;

    // Next-state, counter, pending divisor and sticky error logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        din_d   = din_q;
        err_d   = err_q;

        if (ERR_CLR) begin
            err_d = 1'b0;
        end
        if (accept && !req_legal) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_legal) begin
                        pend_d  = REQ_DIV;
                        state_d = S_LOAD;
                    end
                end else if (RUN_REQ) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (req_legal) begin
                        pend_d  = REQ_DIV;
                        cnt_d   = QLOAD;
                        state_d = S_STOP;
                    end
                end else if (!RUN_REQ) begin
                    state_d = S_IDLE;
                end
            end
            S_STOP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_LOAD: begin
                cnt_d   = QLOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = RUN_REQ ? S_RUN : S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // The divisor is presented as LOAD begins and held until the next LOAD.
        if (state_d == S_LOAD) begin
            din_d = pend_d;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            pend_q  <= 32'd1;
            din_q   <= 32'd1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        ENABLE     = 1'b0;
        CONFIG_DIV = 1'b0;
        BUSY       = 1'b0;
        unique case (1'b1)
            (state_q == S_RUN):    ENABLE     = 1'b1;
            (state_q == S_LOAD): begin
                CONFIG_DIV = 1'b1;
                BUSY       = 1'b1;
            end
            (state_q == S_STOP),
            (state_q == S_SETTLE): BUSY       = 1'b1;
            default: ;
        endcase
    end

    assign REQ_READY = ready;
    assign DIN_n     = din_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_div_config_ctrl.sv
// tb_div_config_ctrl: directed and random checks of div_config_ctrl.
// Expected outputs come from a timeline model of the update sequence.
module tb_div_config_ctrl;

    localparam int unsigned Q     = 2;
    localparam logic [31:0] MIN_D = 32'd2;
    localparam logic [31:0] MAX_D = 32'd1000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ_VALID;
    logic [31:0] REQ_DIV;
    logic        REQ_READY;
    logic        RUN_REQ;
    logic        ERR_CLR;
    logic [31:0] DIN_n;
    logic        CONFIG_DIV;
    logic        ENABLE;
    logic        BUSY;
    logic        ERR;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: running flag, and a sequence measured in edges since accept.
    bit          m_run;
    bit          m_seq;
    int          m_t;
    int          m_len;
    int          m_off;
    logic [31:0] m_pend;
    logic [31:0] m_din;
    bit          m_err;

    div_config_ctrl #(
        .QUIET_CYCLES(Q),
        .MIN_DIV     (MIN_D),
        .MAX_DIV     (MAX_D)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_VALID (REQ_VALID),
        .REQ_DIV   (REQ_DIV),
        .REQ_READY (REQ_READY),
        .RUN_REQ   (RUN_REQ),
        .ERR_CLR   (ERR_CLR),
        .DIN_n     (DIN_n),
        .CONFIG_DIV(CONFIG_DIV),
        .ENABLE    (ENABLE),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] d);
        return (d != 32'd0) && (d >= MIN_D) && (d <= MAX_D);
    endfunction

    task automatic model_edge();
        if (RESET) begin
            m_run  = 1'b0;
            m_seq  = 1'b0;
            m_t    = 0;
            m_pend = 32'd1;
            m_din  = 32'd1;
            m_err  = 1'b0;
        end else begin
            if (ERR_CLR) m_err = 1'b0;
            if (m_seq) begin
                m_t++;
                if (m_t == m_off) m_din = m_pend;
                if (m_t == m_len) begin
                    m_seq = 1'b0;
                    m_run = RUN_REQ;
                end
            end else if (REQ_VALID) begin
                if (legal(REQ_DIV)) begin
                    m_seq  = 1'b1;
                    m_t    = 0;
                    m_pend = REQ_DIV;
                    if (m_run) begin
                        m_len = 2 * Q + 1;
                        m_off = Q;
                    end else begin
                        m_len = Q + 1;
                        m_off = 0;
                        m_din = REQ_DIV;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                m_run = RUN_REQ;
            end
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
        chk("enable", 32'(ENABLE), 32'(!m_seq && m_run));
        chk("config", 32'(CONFIG_DIV), 32'(m_seq && (m_t == m_off)));
        chk("busy",   32'(BUSY), 32'(m_seq));
        chk("ready",  32'(REQ_READY), 32'(!m_seq));
        chk("err",    32'(ERR), 32'(m_err));
        chk("din",    DIN_n, m_din);
    endtask

    initial begin
        int pulses;
        RESET     = 1'b1;
        REQ_VALID = 1'b0;
        REQ_DIV   = 32'd0;
        RUN_REQ   = 1'b1;
        ERR_CLR   = 1'b0;
        m_len     = 0;
        m_off     = 0;

        // Reset with RUN_REQ high
        cyc();
        cyc();
        chk("rst_enable", 32'(ENABLE), 32'd0);
        chk("rst_din", DIN_n, 32'd1);
        RESET = 1'b0;
        cyc();
        chk("run_enable", 32'(ENABLE), 32'd1);
        chk("run_busy", 32'(BUSY), 32'd0);
        chk("run_err", 32'(ERR), 32'd0);

        // Divisor 3 while running
        REQ_VALID = 1'b1;
        REQ_DIV   = 32'd3;
        cyc();
        REQ_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("seq3_enable", 32'(ENABLE), 32'd0);
            chk("seq3_ready", 32'(REQ_READY), 32'd0);
            chk("seq3_config", 32'(CONFIG_DIV), 32'(i == 2));
            if (i >= 2) chk("seq3_din", DIN_n, 32'd3);
            cyc();
        end
        chk("seq3_restart", 32'(ENABLE), 32'd1);

        // Divisor 7 while idle
        RUN_REQ = 1'b0;
        cyc();
        chk("idle_enable", 32'(ENABLE), 32'd0);
        REQ_VALID = 1'b1;
        REQ_DIV   = 32'd7;
        cyc();
        REQ_VALID = 1'b0;
        chk("idle_config", 32'(CONFIG_DIV), 32'd1);
        chk("idle_din", DIN_n, 32'd7);
        chk("idle_load_en", 32'(ENABLE), 32'd0);
        cyc();
        cyc();
        chk("idle_settle", 32'(BUSY), 32'd1);
        cyc();
        chk("idle_back_busy", 32'(BUSY), 32'd0);
        chk("idle_back_ready", 32'(REQ_READY), 32'd1);

        // Rejected divisor 0, then ERR_CLR
        RUN_REQ = 1'b1;
        cyc();
        chk("rej_pre_run", 32'(ENABLE), 32'd1);
        REQ_VALID = 1'b1;
        REQ_DIV   = 32'd0;
        cyc();
        REQ_VALID = 1'b0;
        chk("rej_err", 32'(ERR), 32'd1);
        chk("rej_enable", 32'(ENABLE), 32'd1);
        chk("rej_din", DIN_n, 32'd7);
        ERR_CLR = 1'b1;
        cyc();
        ERR_CLR = 1'b0;
        chk("errclr", 32'(ERR), 32'd0);

        // Back-to-back requests 5 then 9
        REQ_VALID = 1'b1;
        REQ_DIV   = 32'd5;
        cyc();
        REQ_DIV = 32'd9;
        pulses  = 0;
        for (int i = 0; i < 30 && m_seq; i++) begin
            cyc();
            if (CONFIG_DIV) pulses++;
        end
        chk("b2b_wait_ready", 32'(REQ_READY), 32'd1);
        cyc();
        REQ_VALID = 1'b0;
        if (CONFIG_DIV) pulses++;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (CONFIG_DIV) pulses++;
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_din", DIN_n, 32'd9);
        chk("b2b_enable", 32'(ENABLE), 32'd1);

        // Reset during SETTLE after divisor 4
        REQ_VALID = 1'b1;
        REQ_DIV   = 32'd4;
        cyc();
        REQ_VALID = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("mid_settle_busy", 32'(BUSY), 32'd1);
        chk("mid_settle_din", DIN_n, 32'd4);
        RESET = 1'b1;
        cyc();
        chk("mid_rst_din", DIN_n, 32'd1);
        chk("mid_rst_enable", 32'(ENABLE), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        cyc();
        chk("mid_rst_ready", 32'(REQ_READY), 32'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (CONFIG_DIV) pulses++;
        end
        chk("mid_rst_pulses", 32'(pulses), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            RESET     = ($urandom_range(0, 199) == 0);
            REQ_VALID = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: REQ_DIV = 32'd0;
                1: REQ_DIV = 32'd1;
                2: REQ_DIV = MIN_D;
                3: REQ_DIV = MAX_D;
                4: REQ_DIV = 32'($urandom_range(1001, 5000));
                default: REQ_DIV = 32'($urandom_range(2, 1000));
            endcase
            if ($urandom_range(0, 15) == 0) RUN_REQ = ~RUN_REQ;
            ERR_CLR = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
